// File: rtl/heli_game_ctrl.sv
// heli_game_ctrl: helicopter game FSM owning game state, player position, score, lives and high score.
module heli_game_ctrl #(
    parameter int SCORE_W        = 10,
    parameter int LOC_W          = 10,
    parameter int FIELD_H        = 480,
    parameter int PLAYER_H       = 16,
    parameter int RISE           = 4,
    parameter int FALL           = 2,
    parameter int SCORE_DIV      = 4,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               ClkPort,
    input  logic               reset_n,
    input  logic               start,
    input  logic               pause,
    input  logic               thrust,
    input  logic               frame_tick,
    input  logic               collision,
    output logic [2:0]         state,
    output logic [LOC_W-1:0]   player_loc,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         lives_left,
    output logic               new_hs
);
    localparam logic [2:0] IDLE = 3'd0, PLAY = 3'd1, PAUSE = 3'd2, HIT = 3'd3, NEWHS = 3'd4, GAMEOVER = 3'd5;
    localparam logic [LOC_W-1:0] CENTER = LOC_W'((FIELD_H - PLAYER_H) / 2);
    localparam logic [LOC_W-1:0] LOCMAX = LOC_W'(FIELD_H - PLAYER_H);
    localparam logic signed [LOC_W:0] LOCMAX_S = (LOC_W + 1)'(FIELD_H - PLAYER_H);
    localparam logic signed [LOC_W:0] ZERO_S = '0;
    localparam logic signed [LOC_W:0] RISE_S = (LOC_W + 1)'(RISE);
    localparam logic signed [LOC_W:0] FALL_S = (LOC_W + 1)'(FALL);
    localparam int CNT_MAX = (SCORE_DIV > RESPAWN_FRAMES) ? SCORE_DIV : RESPAWN_FRAMES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCORE_DIV - 1);
    localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [2:0] LIVES_V = 3'(LIVES);

    logic [2:0]         stateNext;
    logic               startQ, pauseQ;
    logic [CNT_W-1:0]   frameCnt, cntNext;
    logic [LOC_W-1:0]   locNext;
    logic [SCORE_W-1:0] scoreNext, hsNext;
    logic [2:0]         livesNext;
    logic               newHsNext;
    logic signed [LOC_W:0] nxtLoc;
    logic               startEdge, pauseEdge, hitTop, hitBottom, boundary, lastHit;

    assign startEdge = start & ~startQ;
    assign pauseEdge = pause & ~pauseQ;
    assign nxtLoc    = thrust ? $signed({1'b0, player_loc}) - RISE_S : $signed({1'b0, player_loc}) + FALL_S;
    assign hitTop    = nxtLoc <= ZERO_S;
    assign hitBottom = nxtLoc >= LOCMAX_S;
    assign boundary  = frame_tick & (hitTop | hitBottom);
    assign lastHit   = frame_tick & (frameCnt == HIT_LAST);

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = IDLE;
        case (state)
            IDLE:            stateNext = startEdge ? PLAY : IDLE;
            PLAY:            stateNext = (collision | boundary) ? HIT : pauseEdge ? PAUSE : PLAY;
            PAUSE:           stateNext = pauseEdge ? PLAY : PAUSE;
            HIT:             stateNext = !lastHit ? HIT : (lives_left != 3'd0) ? PLAY : (score > high_score) ? NEWHS : GAMEOVER;
            NEWHS, GAMEOVER: stateNext = startEdge ? IDLE : state;
            default:         stateNext = IDLE;
        endcase
    end

    // Register updates are keyed on the transition being taken, so entry actions land with the state change.
    always_comb begin
        locNext   = player_loc;
        scoreNext = score;
        hsNext    = high_score;
        livesNext = lives_left;
        cntNext   = frameCnt;
        newHsNext = 1'b0;
        if (stateNext == IDLE) begin
            locNext   = CENTER;
            scoreNext = '0;
            livesNext = LIVES_V;
            cntNext   = '0;
        end else if (state == PLAY && stateNext == HIT) begin
            livesNext = (lives_left == 3'd0) ? 3'd0 : lives_left - 3'd1;
            cntNext   = '0;
            locNext   = collision ? player_loc : hitTop ? '0 : LOCMAX;
        end else if (state == PLAY && stateNext == PLAY && frame_tick) begin
            locNext   = nxtLoc[LOC_W-1:0];
            cntNext   = (frameCnt == DIV_LAST) ? '0 : frameCnt + 1'b1;
            scoreNext = (frameCnt == DIV_LAST && score != '1) ? score + 1'b1 : score;
        end else if (state == HIT && frame_tick) begin
            cntNext   = lastHit ? '0 : frameCnt + 1'b1;
            locNext   = (stateNext == PLAY) ? CENTER : player_loc;
            hsNext    = (stateNext == NEWHS) ? score : high_score;
            newHsNext = stateNext == NEWHS;
        end
    end

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            startQ     <= 1'b0;
            pauseQ     <= 1'b0;
            player_loc <= CENTER;
            score      <= '0;
            high_score <= '0;
            lives_left <= LIVES_V;
            frameCnt   <= '0;
            new_hs     <= 1'b0;
        end else begin
            startQ     <= start;
            pauseQ     <= pause;
            player_loc <= locNext;
            score      <= scoreNext;
            high_score <= hsNext;
            lives_left <= livesNext;
            frameCnt   <= cntNext;
            new_hs     <= newHsNext;
        end
    end
endmodule

// File: tb/tb_heli_game_ctrl.sv
// tb_heli_game_ctrl: directed and randomized checks of heli_game_ctrl against a behavioural game model.
module tb_heli_game_ctrl;
    localparam int CENTER = 232, LOCMAX = 464, LIVES = 3, RESPAWN = 60, SCORE_DIV = 4, RISE = 4, FALL = 2, SMAX = 1023;

    logic ClkPort = 1'b0, reset_n = 1'b0, start = 1'b0, pause = 1'b0, thrust = 1'b0, frame_tick = 1'b0, collision = 1'b0;
    logic [2:0] state, lives_left, state2, lives2, score2, hs2;
    logic [9:0] player_loc, score, high_score, loc2;
    logic new_hs, newHs2;
    int nCmp = 0, nBad = 0, hsPulses = 0;
    int mState, mLoc, mScore, mHs, mLives, mCnt, mHit, nxt;
    bit mNewHs, mStartQ, mPauseQ, se, pe;

    heli_game_ctrl dut (
        .ClkPort(ClkPort), .reset_n(reset_n), .start(start), .pause(pause), .thrust(thrust),
        .frame_tick(frame_tick), .collision(collision), .state(state), .player_loc(player_loc),
        .score(score), .high_score(high_score), .lives_left(lives_left), .new_hs(new_hs)
    );

    heli_game_ctrl #(.SCORE_W(3), .SCORE_DIV(1)) dut2 (
        .ClkPort(ClkPort), .reset_n(reset_n), .start(start), .pause(pause), .thrust(thrust),
        .frame_tick(frame_tick), .collision(collision), .state(state2), .player_loc(loc2),
        .score(score2), .high_score(hs2), .lives_left(lives2), .new_hs(newHs2)
    );

    wire [36:0] dutVec = {state, player_loc, score, high_score, lives_left, new_hs};
    wire [36:0] modelVec = {3'(mState), 10'(mLoc), 10'(mScore), 10'(mHs), 3'(mLives), mNewHs};

    always #5 ClkPort = ~ClkPort;

    initial forever begin
        @(negedge ClkPort);
        if (new_hs) hsPulses++;
    end

    task automatic enterHit();
        mState = 3;
        mLives = (mLives > 0) ? mLives - 1 : 0;
        mCnt = 0;
        mHit = 0;
    endtask

    // Game model: 0 idle, 1 play, 2 pause, 3 hit, 4 new high score, 5 game over.
    initial forever begin
        @(posedge ClkPort or negedge reset_n);
        if (!reset_n) begin
            mState = 0; mLoc = CENTER; mScore = 0; mHs = 0; mLives = LIVES;
            mCnt = 0; mHit = 0; mNewHs = 0; mStartQ = 0; mPauseQ = 0;
        end else begin
            se = start && !mStartQ;
            pe = pause && !mPauseQ;
            mStartQ = start;
            mPauseQ = pause;
            mNewHs = 0;
            if (mState == 0) begin
                if (se) mState = 1;
            end else if (mState == 1) begin
                nxt = thrust ? mLoc - RISE : mLoc + FALL;
                if (collision) enterHit();
                else if (frame_tick && nxt <= 0) begin mLoc = 0; enterHit(); end
                else if (frame_tick && nxt >= LOCMAX) begin mLoc = LOCMAX; enterHit(); end
                else if (pe) mState = 2;
                else if (frame_tick) begin
                    mLoc = nxt;
                    mCnt++;
                    if (mCnt == SCORE_DIV) begin
                        mCnt = 0;
                        if (mScore < SMAX) mScore++;
                    end
                end
            end else if (mState == 2) begin
                if (pe) mState = 1;
            end else if (mState == 3) begin
                if (frame_tick) begin
                    mHit++;
                    if (mHit == RESPAWN) begin
                        if (mLives > 0) begin mLoc = CENTER; mState = 1; end
                        else if (mScore > mHs) begin mHs = mScore; mNewHs = 1; mState = 4; end
                        else mState = 5;
                    end
                end
            end else if (se) begin
                mState = 0; mScore = 0; mLoc = CENTER; mLives = LIVES; mCnt = 0;
            end
        end
    end

    task automatic doReset();
        reset_n = 1'b0;
        @(negedge ClkPort);
        reset_n = 1'b1;
        @(negedge ClkPort);
    endtask

    task automatic pressStart();
        start = 1'b1;
        @(negedge ClkPort);
        start = 1'b0;
        @(negedge ClkPort);
    endtask

    task automatic frames(input int n, input logic thr);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            thrust = thr;
            @(negedge ClkPort);
            frame_tick = 1'b0;
            @(negedge ClkPort);
        end
    endtask

    task automatic hitOnce();
        collision = 1'b1;
        @(negedge ClkPort);
        collision = 1'b0;
        @(negedge ClkPort);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge ClkPort);
        nCmp++; if (state !== 3'd0) begin nBad++; $display("FAIL rst_state got %0d want 0", state); end
        nCmp++; if (player_loc !== 10'd232) begin nBad++; $display("FAIL rst_loc got %0d want 232", player_loc); end
        nCmp++; if (score !== 10'd0 || high_score !== 10'd0) begin nBad++; $display("FAIL rst_score got %0d/%0d want 0/0", score, high_score); end
        nCmp++; if (lives_left !== 3'd3 || new_hs !== 1'b0) begin nBad++; $display("FAIL rst_lives got %0d/%0d want 3/0", lives_left, new_hs); end
        reset_n = 1'b1;
        @(negedge ClkPort);
    endtask

    task automatic test_fall();
        pressStart();
        nCmp++; if (state !== 3'd1) begin nBad++; $display("FAIL fall_start got %0d want 1", state); end
        frames(10, 1'b0);
        nCmp++; if (player_loc !== 10'd252) begin nBad++; $display("FAIL fall_loc got %0d want 252", player_loc); end
        nCmp++; if (score !== 10'd2 || lives_left !== 3'd3) begin nBad++; $display("FAIL fall_score got %0d/%0d want 2/3", score, lives_left); end
        nCmp++; if (dutVec !== modelVec) begin nBad++; $display("FAIL fall_model got %h want %h", dutVec, modelVec); end
    endtask

    task automatic test_ceiling();
        doReset();
        pressStart();
        frames(57, 1'b1);
        nCmp++; if (state !== 3'd1 || player_loc !== 10'd4) begin nBad++; $display("FAIL ceil_pre got %0d/%0d want 1/4", state, player_loc); end
        frames(1, 1'b1);
        nCmp++; if (state !== 3'd3 || player_loc !== 10'd0) begin nBad++; $display("FAIL ceil_clamp got %0d/%0d want 3/0", state, player_loc); end
        nCmp++; if (lives_left !== 3'd2 || score !== 10'd14) begin nBad++; $display("FAIL ceil_lives got %0d/%0d want 2/14", lives_left, score); end
        frames(59, 1'b0);
        nCmp++; if (state !== 3'd3) begin nBad++; $display("FAIL ceil_wait got %0d want 3", state); end
        frames(1, 1'b0);
        nCmp++; if (state !== 3'd1 || player_loc !== 10'd232 || score !== 10'd14) begin nBad++; $display("FAIL ceil_respawn got %0d/%0d/%0d want 1/232/14", state, player_loc, score); end
        nCmp++; if (dutVec !== modelVec) begin nBad++; $display("FAIL ceil_model got %h want %h", dutVec, modelVec); end
    endtask

    task automatic test_collision_frame();
        doReset();
        pressStart();
        frames(20, 1'b0);
        nCmp++; if (score !== 10'd5 || player_loc !== 10'd272) begin nBad++; $display("FAIL cf_pre got %0d/%0d want 5/272", score, player_loc); end
        frame_tick = 1'b1;
        collision = 1'b1;
        @(negedge ClkPort);
        frame_tick = 1'b0;
        collision = 1'b0;
        nCmp++; if (state !== 3'd3 || score !== 10'd5 || player_loc !== 10'd272) begin nBad++; $display("FAIL cf_hit got %0d/%0d/%0d want 3/5/272", state, score, player_loc); end
        nCmp++; if (dutVec !== modelVec) begin nBad++; $display("FAIL cf_model got %h want %h", dutVec, modelVec); end
    endtask

    task automatic test_newhs();
        int base;
        doReset();
        pressStart();
        frames(28, 1'b0);
        base = hsPulses;
        for (int k = 0; k < 3; k++) begin
            hitOnce();
            nCmp++; if (state !== 3'd3 || lives_left !== 3'(2 - k)) begin nBad++; $display("FAIL nhs_hit%0d got %0d/%0d want 3/%0d", k, state, lives_left, 2 - k); end
            frames(60, 1'b0);
        end
        nCmp++; if (state !== 3'd4 || high_score !== 10'd7) begin nBad++; $display("FAIL nhs_state got %0d/%0d want 4/7", state, high_score); end
        nCmp++; if (hsPulses - base !== 1 || new_hs !== 1'b0) begin nBad++; $display("FAIL nhs_pulse got %0d/%0d want 1/0", hsPulses - base, new_hs); end
        nCmp++; if (dutVec !== modelVec) begin nBad++; $display("FAIL nhs_model got %h want %h", dutVec, modelVec); end
        pressStart();
        nCmp++; if (state !== 3'd0 || high_score !== 10'd7 || score !== 10'd0) begin nBad++; $display("FAIL nhs_idle got %0d/%0d/%0d want 0/7/0", state, high_score, score); end
    endtask

    task automatic test_gameover();
        int base;
        pressStart();
        frames(28, 1'b0);
        base = hsPulses;
        for (int k = 0; k < 3; k++) begin
            hitOnce();
            frames(60, 1'b0);
        end
        nCmp++; if (state !== 3'd5 || high_score !== 10'd7 || score !== 10'd7) begin nBad++; $display("FAIL go_state got %0d/%0d/%0d want 5/7/7", state, high_score, score); end
        nCmp++; if (hsPulses - base !== 0) begin nBad++; $display("FAIL go_pulse got %0d want 0", hsPulses - base); end
        nCmp++; if (dutVec !== modelVec) begin nBad++; $display("FAIL go_model got %h want %h", dutVec, modelVec); end
    endtask

    task automatic test_pause();
        pressStart();
        nCmp++; if (state !== 3'd0 || score !== 10'd0 || high_score !== 10'd7) begin nBad++; $display("FAIL pz_idle got %0d/%0d/%0d want 0/0/7", state, score, high_score); end
        pressStart();
        frames(5, 1'b0);
        pause = 1'b1;
        @(negedge ClkPort);
        nCmp++; if (state !== 3'd2) begin nBad++; $display("FAIL pz_enter got %0d want 2", state); end
        collision = 1'b1;
        frames(20, 1'b0);
        collision = 1'b0;
        nCmp++; if (state !== 3'd2 || player_loc !== 10'd242 || score !== 10'd1 || lives_left !== 3'd3 || high_score !== 10'd7) begin
            nBad++; $display("FAIL pz_frozen got %0d/%0d/%0d/%0d/%0d want 2/242/1/3/7", state, player_loc, score, lives_left, high_score);
        end
        pause = 1'b0;
        @(negedge ClkPort);
        pause = 1'b1;
        @(negedge ClkPort);
        pause = 1'b0;
        nCmp++; if (state !== 3'd1) begin nBad++; $display("FAIL pz_resume got %0d want 1", state); end
        nCmp++; if (dutVec !== modelVec) begin nBad++; $display("FAIL pz_model got %h want %h", dutVec, modelVec); end
        #3 reset_n = 1'b0;
        #1;
        nCmp++; if (state !== 3'd0 || player_loc !== 10'd232 || score !== 10'd0 || high_score !== 10'd0 || lives_left !== 3'd3 || new_hs !== 1'b0) begin
            nBad++; $display("FAIL async_rst got %0d/%0d/%0d/%0d/%0d want 0/232/0/0/3", state, player_loc, score, high_score, lives_left);
        end
        @(negedge ClkPort);
        reset_n = 1'b1;
        @(negedge ClkPort);
    endtask

    task automatic test_saturation();
        doReset();
        pressStart();
        frames(12, 1'b0);
        nCmp++; if (score2 !== 3'd7) begin nBad++; $display("FAIL sat_score got %0d want 7", score2); end
        nCmp++; if (score !== 10'd3 || player_loc !== 10'd256) begin nBad++; $display("FAIL sat_main got %0d/%0d want 3/256", score, player_loc); end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 8000; i++) begin
            start      = ($urandom_range(0, 19) == 0);
            pause      = ($urandom_range(0, 29) == 0);
            collision  = ($urandom_range(0, 249) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            thrust     = ($urandom_range(0, 2) != 0);
            @(negedge ClkPort);
            nCmp++; if (dutVec !== modelVec) begin nBad++; $display("FAIL rand_cycle%0d got %h want %h", i, dutVec, modelVec); end
        end
        start = 1'b0; pause = 1'b0; collision = 1'b0; frame_tick = 1'b0; thrust = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fall();
        test_ceiling();
        test_collision_frame();
        test_newhs();
        test_gameover();
        test_pause();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
